// File: rtl/avg4_shared_ctrl.sv
// Four-channel acquisition sequencer. One halving adder is time-shared over three
// states to form the mean of four samples, which is then offered over dav_/rfd.
module avg4_shared_ctrl #(
   parameter int W       = 8,
   parameter int TIMEOUT = 255
) (
   input  logic         clock,
   input  logic         reset,
   output logic         soc,
   input  logic         eoc1,
   input  logic         eoc2,
   input  logic         eoc3,
   input  logic         eoc4,
   input  logic [W-1:0] x1,
   input  logic [W-1:0] x2,
   input  logic [W-1:0] x3,
   input  logic [W-1:0] x4,
   output logic         dav_,
   input  logic         rfd,
   output logic [W-1:0] avg,
   output logic         err
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      START, CONV, SAMPLE, AB, CD, FIN, OUT, REL
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [W-1:0]     r1, r2, r3, r4;
   logic [W-1:0]     p1, p2;
   logic [W-1:0]     op_a, op_b;
   logic [W-1:0]     half;
   logic [3:0]       eoc_all;

   // Carry is kept as the result MSB, so the halved sum never overflows.
   function automatic logic [W-1:0] avg2(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return W'(s >> 1);
   endfunction

   assign eoc_all = {eoc1, eoc2, eoc3, eoc4};

   always_comb begin
      op_a = '0;
      op_b = '0;
      case (state)
         AB:      begin op_a = r1; op_b = r2; end
         CD:      begin op_a = r3; op_b = r4; end
         FIN:     begin op_a = p1; op_b = p2; end
         default: begin op_a = '0; op_b = '0; end
      endcase
      half = avg2(op_a, op_b);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= START;
         soc   <= 1'b0;
         dav_  <= 1'b1;
         avg   <= '0;
         err   <= 1'b0;
         cnt   <= '0;
         r1    <= '0;
         r2    <= '0;
         r3    <= '0;
         r4    <= '0;
         p1    <= '0;
         p2    <= '0;
      end else begin
         case (state)
            // After reset soc is low, so it is raised for one cycle before leaving.
            START: begin
               cnt <= '0;
               if (!soc) begin
                  soc <= 1'b1;
               end else if (eoc_all == 4'b0000) begin
                  soc   <= 1'b0;
                  state <= CONV;
               end
            end
            CONV: begin
               if (eoc_all == 4'b1111) begin
                  state <= SAMPLE;
               end else if (cnt == CNT_LAST) begin
                  err   <= 1'b1;
                  soc   <= 1'b1;
                  state <= START;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            SAMPLE: begin
               r1    <= x1;
               r2    <= x2;
               r3    <= x3;
               r4    <= x4;
               state <= AB;
            end
            AB: begin
               p1    <= half;
               state <= CD;
            end
            CD: begin
               p2    <= half;
               state <= FIN;
            end
            FIN: begin
               avg   <= half;
               dav_  <= 1'b0;
               state <= OUT;
            end
            OUT: begin
               if (!rfd) begin
                  dav_  <= 1'b1;
                  state <= REL;
               end
            end
            REL: begin
               if (rfd) begin
                  soc   <= 1'b1;
                  state <= START;
               end
            end
            default: state <= START;
         endcase
      end
   end

endmodule

// File: tb/tb_avg4_shared_ctrl.sv
// Randomized self-checking bench for avg4_shared_ctrl against a plain-arithmetic
// mean model and the handshake timing rules.
module tb_avg4_shared_ctrl;

   localparam int W  = 8;
   localparam int TO = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic         soc;
   logic [3:0]   eoc;
   logic [W-1:0] x1, x2, x3, x4;
   logic         dav_;
   logic         rfd;
   logic [W-1:0] avg;
   logic         err;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_avg = 0;
   int exp_err = 0;

   avg4_shared_ctrl #(.W(W), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .soc(soc),
      .eoc1(eoc[3]), .eoc2(eoc[2]), .eoc3(eoc[1]), .eoc4(eoc[0]),
      .x1(x1), .x2(x2), .x3(x3), .x4(x4),
      .dav_(dav_), .rfd(rfd), .avg(avg), .err(err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic int ref_mean(input int a, input int b, input int c, input int d);
      return ((a + b) / 2 + (c + d) / 2) / 2;
   endfunction

   task automatic scramble_x();
      x1 = W'($urandom); x2 = W'($urandom); x3 = W'($urandom); x4 = W'($urandom);
   endtask

   // mode 0: full transaction, 1: reset while in OUT, 2: reset while in AB
   task automatic convert(input int a, input int b, input int c, input int d,
                          input int conv_wait, input int hold, input int mode);
      int guard;
      logic [3:0] pat;
      guard = 0;
      while (soc !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      chk("soc_wait", int'(soc), 1);
      // partial eoc patterns in START keep soc high
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
         pat = 4'($urandom_range(1, 15));
         eoc = pat;
         step();
         chk("soc_partial", int'(soc), 1);
      end
      eoc = 4'b0000;
      step();
      chk("soc_fall", int'(soc), 0);
      for (int i = 0; i < conv_wait; i++) begin
         pat = 4'($urandom_range(0, 14));
         eoc = pat;
         step();
         chk("conv_soc", int'(soc), 0);
         chk("conv_err", int'(err), exp_err);
      end
      x1 = W'(a); x2 = W'(b); x3 = W'(c); x4 = W'(d);
      eoc = 4'b1111;
      step();                 // edge k
      eoc = 4'($urandom);
      step();                 // k+1: samples latched
      scramble_x();
      if (mode == 2) begin
         reset = 1'b1;
         step();
         reset = 1'b0;
         eoc = 4'b0000;
         exp_avg = 0;
         exp_err = 0;
         chk("rst_ab_dav", int'(dav_), 1);
         chk("rst_ab_avg", int'(avg), 0);
         step();
         chk("rst_ab_soc", int'(soc), 1);
         chk("rst_ab_dav2", int'(dav_), 1);
         return;
      end
      step();                 // k+2
      x1 = 8'd200; x2 = 8'd200; x3 = 8'd200; x4 = 8'd200;
      step();                 // k+3
      chk("dav_pre", int'(dav_), 1);
      chk("avg_hold", int'(avg), exp_avg);
      rfd = (hold == 0) ? 1'b0 : 1'b1;
      step();                 // k+4
      exp_avg = ref_mean(a, b, c, d);
      chk("dav_fall", int'(dav_), 0);
      chk("avg", int'(avg), exp_avg);
      chk("err_keep", int'(err), exp_err);
      if (mode == 1) begin
         reset = 1'b1;
         step();
         reset = 1'b0;
         eoc = 4'b0000;
         exp_avg = 0;
         exp_err = 0;
         chk("rst_out_dav", int'(dav_), 1);
         chk("rst_out_avg", int'(avg), 0);
         chk("rst_out_soc", int'(soc), 0);
         chk("rst_out_err", int'(err), 0);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         step();
         chk("out_dav", int'(dav_), 0);
         chk("out_avg", int'(avg), exp_avg);
         chk("out_soc", int'(soc), 0);
      end
      rfd = 1'b0;
      step();
      chk("dav_rise", int'(dav_), 1);
      chk("rel_soc", int'(soc), 0);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
         step();
         chk("rel_wait_soc", int'(soc), 0);
      end
      eoc = 4'b0000;
      rfd = 1'b1;
      step();
      chk("soc_rise", int'(soc), 1);
      chk("avg_after", int'(avg), exp_avg);
   endtask

   task automatic timeout_run();
      int guard;
      guard = 0;
      while (soc !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      chk("to_soc_wait", int'(soc), 1);
      eoc = 4'b0000;
      step();                 // CONV entry
      eoc = 4'b1110;          // eoc4 stuck low
      for (int i = 1; i < TO; i++) begin
         step();
         chk("to_err_early", int'(err), exp_err);
         chk("to_soc_early", int'(soc), 0);
      end
      step();
      exp_err = 1;
      chk("to_err", int'(err), 1);
      chk("to_soc", int'(soc), 1);
      eoc = 4'b0000;
   endtask

   initial begin
      reset = 1'b1;
      rfd   = 1'b1;
      eoc   = 4'b0000;
      scramble_x();
      step();
      step();
      chk("rst_soc", int'(soc), 0);
      chk("rst_dav", int'(dav_), 1);
      chk("rst_avg", int'(avg), 0);
      chk("rst_err", int'(err), 0);
      reset = 1'b0;
      step();
      chk("rel_soc1", int'(soc), 1);

      convert(1, 2, 3, 4, 0, 0, 0);
      convert(255, 255, 255, 255, 2, 5, 0);
      convert(3, 0, 3, 0, 1, 1, 0);
      convert(1, 0, 0, 0, 0, 0, 0);
      convert(9, 9, 9, 9, TO - 1, 2, 0);   // completion on the timeout edge wins
      timeout_run();
      convert(10, 20, 30, 40, 3, 1, 0);
      timeout_run();
      convert(50, 60, 70, 80, 0, 5, 1);
      convert(7, 8, 9, 10, 0, 0, 2);
      for (int n = 0; n < 25; n++)
         convert(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, TO - 1)), int'($urandom_range(0, 4)), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
